edge_delay_meter: RTL and testbench
===================================

// Module: edge_delay_meter
// PURPOSE
//  Measures the delay-line output against its source: the clk-cycle count from a rising edge on
//  refIn to the first rising edge on dlyIn, and the refIn period. Closes the loop on the phase
//  delay path (check programmed waitCnt against actual delay; derive waitCnt from period).
//  Sits beside the delay stage, fed by the raw input and the delayed output.
// PARAMETERS
//  CNT_SIZE     11  width of timer and result counts; same width as the delay-stage waitCnt
//  SYNC_STAGES  2   flip-flop synchronizer depth on refIn and dlyIn (>=2)
// PORTS
//  clk        in   1         system clock
//  rst        in   1         synchronous, active-high reset
//  refIn      in   1         reference signal (async to clk)
//  dlyIn      in   1         delayed copy of refIn (async to clk)
//  delayCnt   out  CNT_SIZE  last valid refIn-rise to dlyIn-rise count, cycles
//  periodCnt  out  CNT_SIZE  last valid refIn-rise to refIn-rise count, cycles
//  measValid  out  1         1-cycle pulse: delayCnt/periodCnt just updated
//  missFlag   out  1         1-cycle pulse: a period closed with no dlyIn rise
//  timeout    out  1         level: no refIn rise within 2^CNT_SIZE-1 cycles
// BEHAVIOUR
//  - Reset: delayCnt=0, periodCnt=0, measValid=0, missFlag=0, timeout=0. Synchronizer and
//    edge-history flops cleared to 0. Timer=0, dlyCaught=0, state IDLE.
//  - Both inputs use identical SYNC_STAGES chains, so sync latency cancels in the counts.
//    Rise = synced bit 1 while previous synced bit 0.
//  - Timer = cycles since the last refRise. Loaded with 1 on the cycle after refRise. Increments
//    by 1 per cycle, saturating at all-ones.
//  - FSM states:
//    IDLE: on refRise -> MEASURE (timer<=1, dlyCaught<=dlyRise, delayCap<=0 if dlyRise).
//      dlyRise alone is ignored.
//    MEASURE, in priority order each cycle:
//      * refRise: periodCap<=timer.
//          If dlyCaught: delayCnt<=delayCap, periodCnt<=timer, measValid=1 next cycle.
//          Else: missFlag=1 next cycle; delayCnt/periodCnt hold.
//          Then start a new period: timer<=1, dlyCaught<=dlyRise (delayCap<=0 if dlyRise).
//          Stay MEASURE.
//      * dlyRise and !dlyCaught (no refRise this cycle): delayCap<=timer, dlyCaught<=1.
//        Later dlyRise in the same period is ignored.
//      * timer==all-ones and no refRise: timeout<=1, -> IDLE; outputs hold.
//  - Simultaneous refRise+dlyRise: the dly edge belongs to the new period (delay 0). The closing
//    period is judged only on its own dlyCaught.
//  - timeout clears on the cycle after the next refRise.
//  - The first valid result needs two refIn rises after reset or timeout.
//  - Latency: measValid is high the cycle after the synced refRise. Outputs are registered.
//  - Counts never wrap. delayCap < periodCnt is guaranteed, since the capture precedes refRise.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE, MEASURE) and CNT_SIZE default constant, reused
//    by the delay stage.
//  - Sub-module sync_rise_detect (SYNC_STAGES param; ports clk, rst, d, q, rise), instanced twice.
//  - Top level holds the FSM, timer, and capture/output registers only.
// TESTING
//  1. refIn period 100 clk, 50% duty; dlyIn = refIn lagged 30 -> from the 2nd refIn rise,
//     measValid pulses each period; delayCnt=30, periodCnt=100.
//  2. dlyIn == refIn (lag 0) -> delayCnt=0, periodCnt=100; missFlag never asserted.
//  3. dlyIn held low for one period, then lag 30 resumes -> exactly one missFlag pulse.
//     No measValid for that period; outputs hold 30/100; next period valid again.
//  4. Three dlyIn rises at lags 10/20/40 in one period -> delayCnt=10.
//  5. refIn stopped low -> timeout=1 exactly 2047 cycles after the last rise, state IDLE.
//     Restart -> timeout=0 after the first rise; measValid at the 2nd rise.
//  6. rst pulsed mid-MEASURE (timer ~50) -> all outputs 0 next cycle.
//     No measValid until two further refIn rises.
//  7. Chained with the delay stage, waitCnt=25, period 200 -> delayCnt equals the delay stage's
//     measured lag (25 + its fixed pipeline offset); periodCnt=200.

Source files
------------

// File: rtl/edge_delay_meter_pkg.sv
// Shared definitions for the phase-delay path: measurement FSM encoding and the
// default count width used by both the delay stage and the edge delay meter.
package edge_delay_meter_pkg;

  localparam int CNT_SIZE_DEF    = 11;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } measState_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous input, followed by a one-cycle
// rising-edge detector on the synchronized level.
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   prevReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      syncReg <= '0;
      prevReg <= 1'b0;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], d};
      prevReg <= syncReg[SYNC_STAGES-1];
    end
  end

  assign q    = syncReg[SYNC_STAGES-1];
  assign rise = syncReg[SYNC_STAGES-1] & ~prevReg;

endmodule

// File: rtl/edge_delay_meter.sv
// Measures refIn-rise to first dlyIn-rise delay and the refIn period in clk cycles,
// with pulses for a completed measurement or a period that saw no delayed edge.
module edge_delay_meter
  import edge_delay_meter_pkg::*;
#(
  parameter int CNT_SIZE    = CNT_SIZE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                refIn,
  input  logic                dlyIn,
  output logic [CNT_SIZE-1:0] delayCnt,
  output logic [CNT_SIZE-1:0] periodCnt,
  output logic                measValid,
  output logic                missFlag,
  output logic                timeout
);

  localparam logic [CNT_SIZE-1:0] TIMER_MAX = '1;
  localparam logic [CNT_SIZE-1:0] CNT_ONE   = {{(CNT_SIZE-1){1'b0}}, 1'b1};

  logic refRise;
  logic dlyRise;
  logic refLvl;
  logic dlyLvl;
  logic unusedLvl;

  measState_t          stateReg;
  logic [CNT_SIZE-1:0] timerReg;
  logic [CNT_SIZE-1:0] delayCapReg;
  logic                dlyCaughtReg;

  // Identical chains on both inputs so synchronizer latency cancels out of the counts.
  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) refSync (
    .clk  (clk),
    .rst  (rst),
    .d    (refIn),
    .q    (refLvl),
    .rise (refRise)
  );

  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) dlySync (
    .clk  (clk),
    .rst  (rst),
    .d    (dlyIn),
    .q    (dlyLvl),
    .rise (dlyRise)
  );

  assign unusedLvl = refLvl ^ dlyLvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= IDLE;
      timerReg     <= '0;
      delayCapReg  <= '0;
      dlyCaughtReg <= 1'b0;
      delayCnt     <= '0;
      periodCnt    <= '0;
      measValid    <= 1'b0;
      missFlag     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      measValid <= 1'b0;
      missFlag  <= 1'b0;

      if (refRise) begin
        timerReg <= CNT_ONE;
      end else if (timerReg != TIMER_MAX) begin
        timerReg <= timerReg + CNT_ONE;
      end

      case (stateReg)
        IDLE: begin
          // A lone dlyIn edge here has no reference and is dropped.
          if (refRise) begin
            stateReg     <= MEASURE;
            timeout      <= 1'b0;
            dlyCaughtReg <= dlyRise;
            if (dlyRise) delayCapReg <= '0;
          end
        end
        MEASURE: begin
          if (refRise) begin
            if (dlyCaughtReg) begin
              delayCnt  <= delayCapReg;
              periodCnt <= timerReg;
              measValid <= 1'b1;
            end else begin
              missFlag <= 1'b1;
            end
            // A coincident dlyIn edge opens the new period with zero delay.
            timeout      <= 1'b0;
            dlyCaughtReg <= dlyRise;
            if (dlyRise) delayCapReg <= '0;
          end else if (dlyRise && !dlyCaughtReg) begin
            delayCapReg  <= timerReg;
            dlyCaughtReg <= 1'b1;
          end else if (timerReg == TIMER_MAX) begin
            timeout  <= 1'b1;
            stateReg <= IDLE;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_delay_meter.sv
// Randomized and directed bench for edge_delay_meter against an elapsed-time model.
module tb_edge_delay_meter;

  localparam int TMAX = 2047;
  localparam int LAT  = 3;  // sync depth + registered output

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        refIn = 1'b0;
  logic        dlyIn = 1'b0;
  logic [10:0] delayCnt;
  logic [10:0] periodCnt;
  logic        measValid;
  logic        missFlag;
  logic        timeout;

  edge_delay_meter dut (
    .clk       (clk),
    .rst       (rst),
    .refIn     (refIn),
    .dlyIn     (dlyIn),
    .delayCnt  (delayCnt),
    .periodCnt (periodCnt),
    .measValid (measValid),
    .missFlag  (missFlag),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int delay;
    int period;
    bit mv;
    bit mf;
    bit to;
  } expT;

  expT expQ[$];
  expT cur;
  expT e;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  measSeen = 0;
  int  missSeen = 0;

  // Model state: when the open period began and when its first delayed edge arrived.
  bit  measuring;
  bit  caught;
  int  refStep;
  int  dlyStep;
  bit  prevR;
  bit  prevD;

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic void modelReset();
    cur = '{0, 0, 1'b0, 1'b0, 1'b0};
    measuring = 1'b0;
    caught = 1'b0;
    prevR = 1'b0;
    prevD = 1'b0;
  endfunction

  function automatic void modelStep(input bit r, input bit d);
    bit rr;
    bit dr;
    int elapsed;
    rr = r & !prevR;
    dr = d & !prevD;
    prevR = r;
    prevD = d;
    elapsed = cyc - refStep;
    if (elapsed > TMAX) elapsed = TMAX;
    cur.mv = 1'b0;
    cur.mf = 1'b0;
    if (rr) begin
      if (measuring) begin
        if (caught) begin
          cur.delay  = dlyStep - refStep;
          cur.period = elapsed;
          cur.mv     = 1'b1;
        end else begin
          cur.mf = 1'b1;
        end
      end
      cur.to    = 1'b0;
      measuring = 1'b1;
      refStep   = cyc;
      caught    = dr;
      dlyStep   = cyc;
    end else if (measuring) begin
      if (dr && !caught) begin
        caught  = 1'b1;
        dlyStep = cyc;
      end else if (elapsed == TMAX) begin
        cur.to    = 1'b1;
        measuring = 1'b0;
      end
    end
    expQ.push_back(cur);
  endfunction

  // Compare process: every cycle, DUT outputs against the model's prediction.
  always @(negedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("delayCnt", int'(delayCnt), e.delay);
      chk("periodCnt", int'(periodCnt), e.period);
      chk("measValid", int'(measValid), int'(e.mv));
      chk("missFlag", int'(missFlag), int'(e.mf));
      chk("timeout", int'(timeout), int'(e.to));
      if (measValid) measSeen++;
      if (missFlag) missSeen++;
    end
  end

  task automatic tick(input bit r, input bit d);
    @(negedge clk);
    cyc++;
    rst   = 1'b0;
    refIn = r;
    dlyIn = d;
    modelStep(r, d);
  endtask

  task automatic resetTick();
    expT keep;
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    modelReset();
    if (expQ.size() > 0) begin
      keep = expQ[0];
      expQ.delete();
      expQ.push_back(keep);
    end else begin
      expQ.push_back(cur);
    end
    for (int i = 0; i < LAT; i++) expQ.push_back(cur);
  endtask

  // Square wave on refIn with dlyIn a copy lagged by 'lag'; the delayed pulse
  // belonging to period skipIdx is suppressed.
  task automatic wave(input int period, input int lag, input int len, input int skipIdx, input int g0);
    bit r;
    bit d;
    for (int g = g0; g < len; g++) begin
      r = (g % period) < (period / 2);
      d = 1'b0;
      if (g >= lag && ((g - lag) % period) < (period / 2) && ((g - lag) / period) != skipIdx)
        d = 1'b1;
      tick(r, d);
    end
  endtask

  initial begin
    int base;
    int rs;
    bit r;
    bit d;
    modelReset();
    resetTick();
    resetTick();

    // Lag 30, period 100
    base = measSeen;
    wave(100, 30, 500, -1, 0);
    chk("s1_delay", int'(delayCnt), 30);
    chk("s1_period", int'(periodCnt), 100);
    chk("s1_validCount", measSeen - base, 4);

    // Zero lag
    base = missSeen;
    wave(100, 0, 400, -1, 0);
    chk("s2_delay", int'(delayCnt), 0);
    chk("s2_period", int'(periodCnt), 100);
    chk("s2_missCount", missSeen - base, 0);

    // One period with no delayed edge
    base = missSeen;
    wave(100, 30, 400, 1, 0);
    chk("s3_missCount", missSeen - base, 1);
    chk("s3_delay", int'(delayCnt), 30);
    chk("s3_period", int'(periodCnt), 100);

    // Several delayed edges in one period: first one wins
    for (int g = 0; g < 300; g++) begin
      r = (g % 100) < 50;
      d = ((g % 100) >= 10 && (g % 100) < 15) || ((g % 100) >= 20 && (g % 100) < 25) ||
          ((g % 100) >= 40 && (g % 100) < 45);
      tick(r, d);
    end
    chk("s4_delay", int'(delayCnt), 10);

    // refIn stops: timeout after the saturating timer
    tick(1'b1, 1'b0);
    rs = cyc;
    for (int i = 0; i < 2060; i++) begin
      tick(1'b0, 1'b0);
      if (cyc == rs + LAT + TMAX - 1) chk("s5_timeoutEarly", int'(timeout), 0);
      if (cyc == rs + LAT + TMAX) chk("s5_timeoutSet", int'(timeout), 1);
    end
    base = measSeen;
    tick(1'b1, 1'b0);
    rs = cyc;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("s5_timeoutHeld", int'(timeout), 1);
    tick(1'b1, 1'b0);
    chk("s5_timeoutClear", int'(timeout), 0);
    wave(100, 30, 200, -1, cyc - rs + 1);
    chk("s5_validCount", measSeen - base, 1);

    // Reset in the middle of a measurement
    wave(100, 30, 250, -1, 0);
    resetTick();
    tick(1'b0, 1'b0);
    chk("s6_delayZero", int'(delayCnt), 0);
    chk("s6_periodZero", int'(periodCnt), 0);
    base = measSeen;
    wave(100, 30, 300, -1, 0);
    chk("s6_validCount", measSeen - base, 2);

    // Delay-stage-like lag: 25 programmed plus a 2-cycle pipeline offset
    wave(200, 27, 600, -1, 0);
    chk("s7_delay", int'(delayCnt), 27);
    chk("s7_period", int'(periodCnt), 200);

    // Random toggling with occasional resets
    r = 1'b0;
    d = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 2999) == 0) begin
        resetTick();
        r = 1'b0;
        d = 1'b0;
      end else begin
        if ($urandom_range(0, 9) == 0) r = ~r;
        if ($urandom_range(0, 6) == 0) d = ~d;
        tick(r, d);
      end
    end

    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
